fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 10, program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_WIDTH, default 9, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins execution at address 0.
REQ-006 stall  input  1  hold current instruction and PC.
REQ-007 halt  input  1  current instruction is HALT (decoded); qualified by instr_valid.
REQ-008 branch_taken  input  1  current instruction is a taken BEQ.
REQ-009 branch_offset  input  8  signed two's-complement PC-relative offset.
REQ-010 jump  input  1  current instruction is JR.
REQ-011 jump_target  input  PC_WIDTH  absolute JR target.
REQ-012 imem_addr  output  PC_WIDTH  address to synchronous instruction ROM (1-cycle read latency).
REQ-013 imem_rdata  input  INSTR_WIDTH  ROM data for the address presented the previous cycle.
REQ-014 instruction  output  INSTR_WIDTH  instruction word to decoder (equals imem_rdata).
REQ-015 instr_valid  output  1  instruction and pc are valid.
REQ-016 pc  output  PC_WIDTH  address of the instruction currently presented.
REQ-017 done  output  1  program has halted.
REQ-018 cycle_count  output  16  cycles spent in RUN since last start.

Function
REQ-019 FSM states IDLE, RUN, HALTED; IDLE->RUN on start; RUN->HALTED on halt&instr_valid&!stall; HALTED->RUN on start; no other transitions.
REQ-020 IDLE: imem_addr=0, instr_valid=0, done=0; pc holds 0.
REQ-021 Start in IDLE or HALTED: imem_addr=0 that cycle; next cycle state=RUN, pc=0, instr_valid=1, cycle_count=0.
REQ-022 RUN: instr_valid=1; imem_addr=next_pc combinationally; pc<=next_pc each edge.
REQ-023 next_pc priority: stall -> pc; halt -> pc; jump -> jump_target; branch_taken -> pc + sign_extend(branch_offset); else pc+1.
REQ-024 Jump and branch_taken asserted together: jump wins.
REQ-025 All PC arithmetic modulo 2^PC_WIDTH; pc+1 at max address wraps to 0; negative offsets wrap likewise.
REQ-026 Redirects are zero-bubble: instruction at target presented the cycle after redirect.
REQ-027 Stall: pc, instruction, instr_valid held; halt, jump, branch ignored while stall=1.
REQ-028 HALTED: instr_valid=0, done=1, pc holds HALT address, imem_addr=pc; redirect inputs ignored.
REQ-029 cycle_count increments by 1 each RUN cycle (including stalled), saturates at 16'hFFFF, holds in IDLE/HALTED.
REQ-030 start while in RUN is ignored.

Reset
REQ-031 Reset asserted at any clock edge, including mid-RUN or mid-stall: state=IDLE, pc=0, cycle_count=0, instr_valid=0, done=0 next cycle; reset overrides start.
REQ-032 imem_addr=0 while reset asserted.

Structure
REQ-033 Shared package holds PC_WIDTH, INSTR_WIDTH defaults and the fetch_state_t enum (IDLE, RUN, HALTED).
REQ-034 Instruction ROM (instr_rom) is external; fetch_unit contains no sub-module, next-PC mux inline.

Verification
REQ-035 Reset, start; ROM addr k holds k+1 -> pc 0,1,2,… on consecutive cycles, instruction tracks ROM, instr_valid=1 from cycle after start.
REQ-036 At pc=5 branch_taken, offset=8'hFD -> next pc=2; at pc=5 offset=8'h7F -> pc=132; jump+branch together with jump_target=40 -> pc=40.
REQ-037 pc=1023 sequential -> next pc=0; pc=1 offset=8'hFC -> pc=1021.
REQ-038 stall held 3 cycles at pc=7 with branch_taken=1 -> pc stays 7, instruction stable, then pc=8 after stall drops (branch deasserted).
REQ-039 halt at pc=9 after 10 RUN cycles -> done=1, instr_valid=0, pc=9, cycle_count=10 held; start -> pc=0, cycle_count=0.
REQ-040 reset asserted mid-RUN at pc=20 with start=1 -> IDLE, pc=0, cycle_count=0, done=0 next cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared defaults and state encoding for the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int PC_WIDTH_DEFAULT    = 10;
    localparam int INSTR_WIDTH_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch sequencer. Drives a synchronous ROM with
//                the next PC combinationally so that redirects cost no bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   halt,
    input  logic                   branch_taken,
    input  logic [7:0]             branch_offset,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   done,
    output logic [15:0]            cycle_count
);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   next_pc;
    logic [PC_WIDTH-1:0]   offset_ext;

    // Sign-extend the branch offset; PC arithmetic then wraps naturally.
    assign offset_ext = PC_WIDTH'($signed(branch_offset));

    // Next-PC selection while running: stall and halt freeze, jump beats branch.
    always_comb begin
        next_pc = pc_q + PC_WIDTH'(1);
        if (stall || halt) begin
            next_pc = pc_q;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_q + offset_ext;
        end
    end

    // Next-state, next-PC, counter and ROM address; reset forces address 0.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        imem_addr = pc_q;
        case (state_q)
            IDLE: begin
                imem_addr = '0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                imem_addr = next_pc;
                pc_d      = next_pc;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (halt && !stall) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                imem_addr = pc_q;
                if (start) begin
                    imem_addr = '0;
                    state_d   = RUN;
                    pc_d      = '0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
        if (reset) begin
            imem_addr = '0;
        end
    end

    // State, PC and cycle counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instruction = imem_rdata;
    assign instr_valid = (state_q == RUN);
    assign done        = (state_q == HALTED);
    assign pc          = pc_q;
    assign cycle_count = cnt_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. ROM model holds
//                (address + 1) truncated to the instruction width.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stall;
    logic              halt;
    logic              branch_taken;
    logic [7:0]        branch_offset;
    logic              jump;
    logic [PC_W-1:0]   jump_target;
    logic [PC_W-1:0]   imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [INSTR_W-1:0] instruction;
    logic              instr_valid;
    logic [PC_W-1:0]   pc;
    logic              done;
    logic [15:0]       cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .PC_WIDTH    (PC_W),
        .INSTR_WIDTH (INSTR_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .done          (done),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle read latency, word k holds k+1.
    function automatic logic [INSTR_W-1:0] rom_val(input logic [PC_W-1:0] a);
        logic [PC_W-1:0] t;
        t = a + 10'd1;
        return t[INSTR_W-1:0];
    endfunction

    always @(posedge clk) imem_rdata <= rom_val(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; branch_offset = 8'h00; jump = 1'b0; jump_target = '0;
        repeat (2) step;
        check("rst_imem_addr", imem_addr, 0);
        check("rst_pc", pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cycle_count, 0);
        reset = 1'b0;
        step;
        check("idle_pc", pc, 0);
        check("idle_valid", instr_valid, 0);

        // Start and sequential fetch
        start = 1'b1; #1;
        check("start_addr", imem_addr, 0);
        step; start = 1'b0;
        check("start_pc", pc, 0);
        check("start_valid", instr_valid, 1);
        check("start_cnt", cycle_count, 0);
        check("start_instr", instruction, 1);
        for (int k = 1; k <= 5; k++) begin
            step;
            check("seq_pc", pc, k);
            check("seq_instr", instruction, k + 1);
        end
        check("seq_cnt", cycle_count, 5);

        // Backward branch from 5 by -3
        branch_taken = 1'b1; branch_offset = 8'hFD; #1;
        check("br_back_addr", imem_addr, 2);
        step; branch_taken = 1'b0;
        check("br_back_pc", pc, 2);
        check("br_back_instr", instruction, 3);
        jump = 1'b1; jump_target = 10'd5;
        step; jump = 1'b0;
        check("jr_pc5", pc, 5);
        branch_taken = 1'b1; branch_offset = 8'h7F;
        step; branch_taken = 1'b0;
        check("br_fwd_pc", pc, 132);
        check("br_fwd_instr", instruction, 133);
        jump = 1'b1; branch_taken = 1'b1; jump_target = 10'd40; branch_offset = 8'hFD;
        step; jump = 1'b0; branch_taken = 1'b0;
        check("jr_prio_pc", pc, 40);
        check("jr_prio_instr", instruction, 41);

        // Wrap-around
        jump = 1'b1; jump_target = 10'd1023;
        step; jump = 1'b0;
        check("max_pc", pc, 1023);
        check("max_instr", instruction, 0);
        step;
        check("wrap_pc", pc, 0);
        check("wrap_instr", instruction, 1);
        step;
        check("pc1", pc, 1);
        branch_taken = 1'b1; branch_offset = 8'hFC;
        step; branch_taken = 1'b0;
        check("neg_wrap_pc", pc, 1021);
        check("neg_wrap_instr", instruction, 510);

        // Stall with branch pending
        jump = 1'b1; jump_target = 10'd7;
        step; jump = 1'b0;
        check("jr_pc7", pc, 7);
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 8'h10;
        for (int k = 0; k < 3; k++) begin
            step;
            check("stall_pc", pc, 7);
            check("stall_instr", instruction, 8);
            check("stall_valid", instr_valid, 1);
        end
        stall = 1'b0; branch_taken = 1'b0;
        step;
        check("unstall_pc", pc, 8);
        check("unstall_instr", instruction, 9);
        start = 1'b1;
        step; start = 1'b0;
        check("run_start_ign", pc, 9);

        // Halt after 10 RUN cycles from a fresh start
        reset = 1'b1;
        step; reset = 1'b0; start = 1'b1;
        step; start = 1'b0;
        repeat (9) step;
        check("pre_halt_pc", pc, 9);
        halt = 1'b1;
        step; halt = 1'b0;
        check("halt_done", done, 1);
        check("halt_valid", instr_valid, 0);
        check("halt_pc", pc, 9);
        check("halt_cnt", cycle_count, 10);
        check("halt_addr", imem_addr, 9);
        jump = 1'b1; jump_target = 10'd33;
        step; jump = 1'b0;
        check("halt_hold_pc", pc, 9);
        check("halt_hold_cnt", cycle_count, 10);
        check("halt_hold_done", done, 1);
        start = 1'b1; #1;
        check("restart_addr", imem_addr, 0);
        step; start = 1'b0;
        check("restart_pc", pc, 0);
        check("restart_cnt", cycle_count, 0);
        check("restart_valid", instr_valid, 1);
        check("restart_done", done, 0);

        // Reset mid-RUN overrides start
        jump = 1'b1; jump_target = 10'd20;
        step; jump = 1'b0;
        check("jr_pc20", pc, 20);
        reset = 1'b1; start = 1'b1; #1;
        check("rst_run_addr", imem_addr, 0);
        step; reset = 1'b0; start = 1'b0;
        check("rst_run_pc", pc, 0);
        check("rst_run_cnt", cycle_count, 0);
        check("rst_run_done", done, 0);
        check("rst_run_valid", instr_valid, 0);
        step;
        check("idle_hold_valid", instr_valid, 0);

        // Counter saturation under a long stall; halt ignored while stalled
        start = 1'b1;
        step; start = 1'b0; stall = 1'b1;
        repeat (65540) step;
        check("sat_cnt", cycle_count, 16'hFFFF);
        check("sat_pc", pc, 0);
        halt = 1'b1;
        step;
        check("stall_halt_valid", instr_valid, 1);
        stall = 1'b0;
        step; halt = 1'b0;
        check("sat_halt_done", done, 1);
        check("sat_halt_cnt", cycle_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
